// File: rtl/serial_parity_framer.sv
// -----------------------------------------------------------------------------
// serial_parity_framer
//
// Collects a valid/ready stream of single-bit results into N-bit frames and
// presents each completed frame, together with its parity bit, on a
// valid/ready output port. The first accepted bit lands in down_data[0].
//
// Parity mode (compile-time macro SERIAL_PARITY_FRAMER_ODD_EN):
//   undefined (default) : even parity, down_parity = ^down_data
//   defined             : odd parity,  down_parity = ~^down_data
//   down_parity resets to 0 in both modes.
//
// Parameters:
//   N            frame length in bits, 2..32 (default 8)
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset
//   up_valid     in   upstream bit valid
//   up_bit       in   upstream data bit
//   up_ready     out  framer can accept a bit this cycle
//   down_valid   out  completed frame available
//   down_data    out  [N-1:0] completed frame, LSB-first
//   down_parity  out  parity of down_data
//   down_ready   in   consumer accepts the frame this cycle
//
// State table:
//   state     | meaning
//   S_COLLECT | assembling a frame, down_valid = 0
//   S_HOLD    | frame complete and held stable, down_valid = 1
// -----------------------------------------------------------------------------
module serial_parity_framer #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  input  logic         up_bit,
  output logic         up_ready,
  output logic         down_valid,
  output logic [N-1:0] down_data,
  output logic         down_parity,
  input  logic         down_ready
);

  localparam int unsigned CW = $clog2(N);

`ifdef SERIAL_PARITY_FRAMER_ODD_EN
  localparam logic PAR_FLIP = 1'b1;
`else
  localparam logic PAR_FLIP = 1'b0;
`endif

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } state_e;

  state_e          state_q,       state_d;
  logic [CW-1:0]   cnt_q,         cnt_d;
  // The last bit of a frame goes straight into down_data, so the assembly
  // register only needs to hold the first N-1 bits.
  logic [N-2:0]    acc_q,         acc_d;
  logic            par_q,         par_d;
  logic [N-1:0]    down_data_q,   down_data_d;
  logic            down_parity_q, down_parity_d;

  logic            up_fire;
  logic            down_fire;
  logic            last_bit;

  // Ready in HOLD only when the pending frame leaves this same cycle, which
  // gives the no-bubble streaming behaviour.
  assign up_ready   = !rst && ((state_q == S_COLLECT) || down_ready);
  assign down_valid = (state_q == S_HOLD);
  assign up_fire    = up_valid && up_ready;
  assign down_fire  = down_valid && down_ready;
  assign last_bit   = (cnt_q == CW'(N - 1));

  assign down_data   = down_data_q;
  assign down_parity = down_parity_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    par_d         = par_q;
    down_data_d   = down_data_q;
    down_parity_d = down_parity_q;

    if (down_fire) begin
      state_d = S_COLLECT;
    end

    // In HOLD, up_fire implies down_fire, and cnt is already 0, so a bit
    // accepted during the handoff simply starts the next frame.
    if (up_fire) begin
      if (last_bit) begin
        down_data_d   = {up_bit, acc_q};
        down_parity_d = par_q ^ up_bit ^ PAR_FLIP;
        cnt_d         = '0;
        par_d         = 1'b0;
        state_d       = S_HOLD;
      end else begin
        for (int i = 0; i < int'(N) - 1; i++) begin
          if (cnt_q == CW'(i)) begin
            acc_d[i] = up_bit;
          end
        end
        cnt_d = cnt_q + CW'(1);
        par_d = par_q ^ up_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_COLLECT;
      cnt_q         <= '0;
      acc_q         <= '0;
      par_q         <= 1'b0;
      down_data_q   <= '0;
      down_parity_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      par_q         <= par_d;
      down_data_q   <= down_data_d;
      down_parity_q <= down_parity_d;
    end
  end

endmodule

// File: tb/tb_serial_parity_framer.sv
module tb_serial_parity_framer;

  localparam int N = 8;

`ifdef SERIAL_PARITY_FRAMER_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         up_valid;
  logic         up_bit;
  logic         up_ready;
  logic         down_valid;
  logic [N-1:0] down_data;
  logic         down_parity;
  logic         down_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stalls   = 0;

  logic [N:0] exp_q[$];   // {parity, data}
  int         pop_cyc[$];

  serial_parity_framer #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .up_valid    (up_valid),
    .up_bit      (up_bit),
    .up_ready    (up_ready),
    .down_valid  (down_valid),
    .down_data   (down_data),
    .down_parity (down_parity),
    .down_ready  (down_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: inputs change just after posedge, so at negedge the handshake
  // seen here is exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst && down_valid && down_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame: got data 0x%0h, expected no frame", down_data);
      end else begin
        logic [N:0] e;
        e = exp_q.pop_front();
        chk("frame_data",   32'(down_data),   32'(e[N-1:0]));
        chk("frame_parity", 32'(down_parity), 32'(e[N]));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic push_exp(input logic [N-1:0] d, input logic p);
    exp_q.push_back({p, d});
  endtask

  task automatic send_bit(input logic b);
    bit ok;
    ok = 1'b0;
    up_valid = 1'b1;
    up_bit   = b;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (up_ready) ok = 1'b1;
      else if (i == 0) stalls++;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: up_ready=%0b, expected 1 within 64 cycles", up_ready);
    end
    up_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [N-1:0] bits, input int from, input int to);
    for (int i = from; i <= to; i++) send_bit(bits[i]);
  endtask

  task automatic send_frame(input logic [N-1:0] d, input logic p);
    push_exp(d, p);
    send_bits(d, 0, N - 1);
  endtask

  task automatic send_frame_gaps(input logic [N-1:0] d, input logic p);
    push_exp(d, p);
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 3)) begin
        up_valid = 1'b0;
        up_bit   = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      send_bit(d[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] r [3];
    int base;

    rst = 1'b1; up_valid = 1'b0; up_bit = 1'b0; down_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("up_ready_in_reset",  32'(up_ready),    32'd0);
    chk("reset_down_valid",   32'(down_valid),  32'd0);
    chk("reset_down_data",    32'(down_data),   32'd0);
    chk("reset_down_parity",  32'(down_parity), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("up_ready_after_reset", 32'(up_ready), 32'd1);
    @(posedge clk); #1;

    // Directed frame 1,0,1,1,0,0,0,0 -> 0x0D, three ones
    send_frame(8'h0D, 1'b1 ^ ODD);
    chk("latency_valid_rise", 32'(down_valid), 32'd1);
    @(posedge clk); #1;
    chk("valid_drop_after_take", 32'(down_valid), 32'd0);

    // All-zero frame
    send_frame(8'h00, 1'b0 ^ ODD);
    repeat (2) @(posedge clk); #1;

    // Back-to-back streaming of three random frames
    base = pop_cyc.size();
    stalls = 0;
    for (int f = 0; f < 3; f++) begin
      r[f] = N'($urandom);
      push_exp(r[f], (^r[f]) ^ ODD);
    end
    for (int f = 0; f < 3; f++) send_bits(r[f], 0, N - 1);
    repeat (2) @(posedge clk); #1;
    chk("stream_stalls", 32'(stalls), 32'd0);
    chk("stream_frames", 32'(pop_cyc.size() - base), 32'd3);
    if (pop_cyc.size() - base == 3) begin
      chk("stream_interval_1", 32'(pop_cyc[base+1] - pop_cyc[base]),   32'd8);
      chk("stream_interval_2", 32'(pop_cyc[base+2] - pop_cyc[base+1]), 32'd8);
    end

    // Backpressure: frame 0xA5 (four ones) held for 5 cycles
    down_ready = 1'b0;
    send_frame(8'hA5, 1'b0 ^ ODD);
    up_valid = 1'b1; up_bit = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_up_ready", 32'(up_ready),    32'd0);
      chk("hold_valid",    32'(down_valid),  32'd1);
      chk("hold_data",     32'(down_data),   32'hA5);
      chk("hold_parity",   32'(down_parity), 32'(1'b0 ^ ODD));
    end
    @(posedge clk); #1;
    down_ready = 1'b1;
    // Bit taken during the handoff becomes bit 0 of 0x4D (four ones)
    push_exp(8'h4D, 1'b0 ^ ODD);
    send_bit(1'b1);
    send_bits(8'h4D, 1, N - 1);
    repeat (2) @(posedge clk); #1;

    // Same frame with and without input gaps
    send_frame(8'h96, 1'b0 ^ ODD);
    send_frame_gaps(8'h96, 1'b0 ^ ODD);
    repeat (2) @(posedge clk); #1;

    // Reset after 3 bits discards the partial frame
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(8'hFF, 1'b0 ^ ODD);
    repeat (2) @(posedge clk); #1;

    // Reset while holding a frame discards it
    down_ready = 1'b0;
    send_bits(8'h3C, 0, N - 1);
    chk("hold_before_rst", 32'(down_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("valid_after_rst_in_hold", 32'(down_valid), 32'd0);
    chk("up_ready_during_rst",     32'(up_ready),   32'd0);
    rst = 1'b0;
    down_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("no_frame_after_rst", 32'(down_valid), 32'd0);

    repeat (4) @(posedge clk); #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
